// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU decoder and
// the execute unit, plus the execute FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier datapath: one partial product per step,
// always WIDTH steps, low WIDTH bits of the product only.
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  // accumulator value after the current iteration
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // latch operands on load, advance one bit per step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative
// multiply behind a start/done handshake; all outputs registered.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  alu_state_t       state;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_res;
  logic             mul_last;
  logic             mul_load;
  logic             mul_step;
  logic             is_mul;

  assign is_mul   = (alu_ctrl_i == ALU_MUL);
  assign mul_load = (state == IDLE) && start_i && is_mul;
  assign mul_step = (state == MUL_RUN);
  assign busy_o   = (state == MUL_RUN);

  // single-cycle result; reserved codes fall through to ADD
  always_comb begin
    alu_res = src_a_i + src_b_i;
    case (alu_ctrl_i)
      ALU_SUB: alu_res = src_a_i - src_b_i;
      ALU_AND: alu_res = src_a_i & src_b_i;
      ALU_OR:  alu_res = src_a_i | src_b_i;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}},
                          $signed(src_a_i) < $signed(src_b_i)};
      default: alu_res = src_a_i + src_b_i;
    endcase
  end

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .load     (mul_load),
    .step     (mul_step),
    .a        (src_a_i),
    .b        (src_b_i),
    .acc_next (mul_res),
    .last     (mul_last)
  );

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      result_o <= '0;
      zero_o   <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (is_mul) begin
              state <= MUL_RUN;
            end else begin
              result_o <= alu_res;
              zero_o   <= (alu_res == '0);
              done_o   <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          if (mul_last) begin
            result_o <= mul_res;
            zero_o   <= (mul_res == '0);
            done_o   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
